// File: rtl/gpio_hub_pkg.sv
// Shared constants and the round-robin search helper for the board GPIO hub.
package gpio_hub_pkg;

  localparam int unsigned DEB_CYC_DEF  = 20000;
  localparam int unsigned HOLD_CYC_DEF = 10000000;
  localparam int unsigned MAX_BTN      = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of pend at or above ptr, wrapping at num (ptr < num <= MAX_BTN).
  function automatic rr_pick_t rr_pick(input logic [MAX_BTN-1:0] pend,
                                       input logic [3:0]         ptr,
                                       input int unsigned        num);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_BTN; k++) begin
      j = 32'(ptr) + k;
      if (j >= num) j = j - num;
      if (k < num && !res.found && pend[j[3:0]]) begin
        res.found = 1'b1;
        res.idx   = j[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_hub_btn_conditioner.sv
// One push-button channel: 2-flop synchroniser, debounce filter and hold
// auto-repeat timer; evt pulses for one cycle per press or repeat.
module btn_conditioner
  import gpio_hub_pkg::*;
#(
  parameter int unsigned DEB_CYC   = DEB_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_EN = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic st,
  output logic evt
);

  localparam int unsigned DW = ($clog2(DEB_CYC) > 0) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned HW = ($clog2(HOLD_CYC) > 0) ? $clog2(HOLD_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          st_q, st_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          rep;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    st_d    = st_q;
    dc_d    = dc_q;
    hc_d    = hc_q;
    rep     = 1'b0;

    if (sync2_q == st_q) begin
      dc_d = '0;
    end else if (dc_q == DEB_LAST) begin
      st_d = sync2_q;
      dc_d = '0;
    end else begin
      dc_d = dc_q + DW'(1);
    end

    // Hold timer runs off the registered level, so the press edge itself restarts it.
    if (REPEAT_EN == 0 || !st_q) begin
      hc_d = '0;
    end else if (hc_q == HOLD_LAST) begin
      hc_d = '0;
      rep  = 1'b1;
    end else begin
      hc_d = hc_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      st_q    <= 1'b0;
      dc_q    <= '0;
      hc_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      st_q    <= st_d;
      dc_q    <= dc_d;
      hc_q    <= hc_d;
    end
  end

  assign st  = st_q;
  assign evt = (st_d & ~st_q) | rep;

endmodule

// File: rtl/gpio_hub.sv
// Board GPIO hub: debounced buttons raise events that are arbitrated
// round-robin onto a valid/ready port with a switch snapshot; LED register.
module gpio_hub
  import gpio_hub_pkg::*;
#(
  parameter int unsigned NUM_BTN   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEB_CYC   = DEB_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_EN = 1,
  localparam int unsigned IDX_W    = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [DATA_W-1:0] sw_in,
  input  logic [DATA_W-1:0] led_wdata,
  input  logic              led_wvalid,
  output logic [DATA_W-1:0] led_out,
  output logic [DATA_W-1:0] tx_data,
  output logic [IDX_W-1:0]  tx_idx,
  output logic              tx_valid,
  input  logic              tx_ready
);

  logic [NUM_BTN-1:0] btn_evt;
  logic [NUM_BTN-1:0] btn_st_unused;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_conditioner #(
      .DEB_CYC  (DEB_CYC),
      .HOLD_CYC (HOLD_CYC),
      .REPEAT_EN(REPEAT_EN)
    ) u_btn (
      .clk   (clk),
      .rstn  (rstn),
      .btn_in(btn_in[gi]),
      .st    (btn_st_unused[gi]),
      .evt   (btn_evt[gi])
    );
  end

  logic [DATA_W-1:0]  sw_s1_q, sw_s1_d;
  logic [DATA_W-1:0]  sw_s2_q, sw_s2_d;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
  logic [DATA_W-1:0]  led_q, led_d;
  rr_pick_t           pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               slot_free;

  always_comb begin
    sw_s1_d    = sw_in;
    sw_s2_d    = sw_s1_q;
    led_d      = led_wvalid ? led_wdata : led_q;
    pick       = rr_pick(MAX_BTN'(pend_q), 4'(rr_ptr_q), NUM_BTN);
    pick_idx   = IDX_W'(pick.idx);
    slot_free  = !tx_valid_q || tx_ready;
    pend_d     = pend_q;
    rr_ptr_d   = rr_ptr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;

    if (slot_free) begin
      tx_valid_d = pick.found;
      if (pick.found) begin
        tx_idx_d         = pick_idx;
        tx_data_d        = sw_s2_q;
        pend_d[pick_idx] = 1'b0;
        rr_ptr_d         = (32'(pick_idx) == NUM_BTN - 1) ? '0 : pick_idx + IDX_W'(1);
      end
    end
    // New events are OR'd after the grant clear so a coincident event survives.
    pend_d = pend_d | btn_evt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      pend_q     <= '0;
      rr_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_idx_q   <= '0;
      led_q      <= '0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      pend_q     <= pend_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_idx_q   <= tx_idx_d;
      led_q      <= led_d;
    end
  end

  assign led_out  = led_q;
  assign tx_data  = tx_data_q;
  assign tx_idx   = tx_idx_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_gpio_hub.sv
// Self-checking bench for gpio_hub: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gpio_hub;

  localparam int NB   = 4;
  localparam int DW   = 8;
  localparam int DEB  = 4;
  localparam int HOLD = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [DW-1:0] sw_in = '0;
  logic [DW-1:0] led_wdata = '0;
  logic          led_wvalid = 1'b0;
  logic          tx_ready = 1'b0;
  logic [DW-1:0] led_out, tx_data;
  logic [1:0]    tx_idx;
  logic          tx_valid;
  logic [DW-1:0] led_out2, tx_data2;
  logic [1:0]    tx_idx2;
  logic          tx_valid2;

  int n_checks = 0;
  int n_err    = 0;
  int n_valid  = 0;
  int n_valid2 = 0;

  always #5 clk = ~clk;

  gpio_hub #(.NUM_BTN(NB), .DATA_W(DW), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_EN(1)) dut (
    .clk(clk), .rstn(rstn), .btn_in(btn_in), .sw_in(sw_in),
    .led_wdata(led_wdata), .led_wvalid(led_wvalid), .led_out(led_out),
    .tx_data(tx_data), .tx_idx(tx_idx), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  gpio_hub #(.NUM_BTN(NB), .DATA_W(DW), .DEB_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_EN(0)) dut_norep (
    .clk(clk), .rstn(rstn), .btn_in(btn_in), .sw_in(sw_in),
    .led_wdata(led_wdata), .led_wvalid(led_wvalid), .led_out(led_out2),
    .tx_data(tx_data2), .tx_idx(tx_idx2), .tx_valid(tx_valid2), .tx_ready(1'b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: delayed raw levels, disagreement run lengths, time held.
  bit            m_s1[NB], m_s2[NB], m_st[NB], m_pend[NB];
  int            m_run[NB], m_held[NB];
  logic [DW-1:0] m_sw1, m_sw2, m_data, m_led;
  bit            m_valid;
  int            m_idx, m_ptr;

  always @(posedge clk) begin
    bit            ev[NB];
    logic [DW-1:0] sw_now;
    int            g;
    if (!rstn) begin
      for (int i = 0; i < NB; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_pend[i] = 0;
        m_run[i] = 0; m_held[i] = 0;
      end
      m_sw1 = '0; m_sw2 = '0; m_data = '0; m_led = '0;
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else begin
      sw_now = m_sw2;
      for (int i = 0; i < NB; i++) begin
        ev[i] = 0;
        if (m_st[i]) begin
          m_held[i]++;
          if (m_held[i] % HOLD == 0) ev[i] = 1;
        end else begin
          m_held[i] = 0;
        end
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_st[i] = m_s2[i];
            m_run[i] = 0;
            if (m_st[i]) ev[i] = 1;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = btn_in[i];
      end
      if (!m_valid || tx_ready) begin
        g = -1;
        for (int k = 0; k < NB; k++)
          if (g < 0 && m_pend[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
        if (g >= 0) begin
          m_valid = 1; m_idx = g; m_data = sw_now;
          m_pend[g] = 0; m_ptr = (g + 1) % NB;
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < NB; i++) if (ev[i]) m_pend[i] = 1;
      m_sw2 = m_sw1;
      m_sw1 = sw_in;
      if (led_wvalid) m_led = led_wdata;
    end
  end

  always @(posedge clk) begin
    #1;
    check("tx_valid", 32'(tx_valid), 32'(m_valid));
    if (m_valid) begin
      check("tx_data", 32'(tx_data), 32'(m_data));
      check("tx_idx", 32'(tx_idx), m_idx);
    end
    check("led_out", 32'(led_out), 32'(m_led));
    if (tx_valid) n_valid++;
    if (tx_valid2) n_valid2++;
  end

  initial begin
    int            q[$];
    int            c0, c1, bi;
    logic [DW-1:0] d_first;
    logic [1:0]    i_first;
    d_first = '0;
    i_first = '0;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_idx", 32'(tx_idx), 0);
    check("rst_led", 32'(led_out), 0);
    rstn = 1'b1;

    // Clean press on button 2
    sw_in = 8'hA5; btn_in = 4'b0100; tx_ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (tx_valid) begin
        q.push_back(c);
        if (q.size() == 1) begin d_first = tx_data; i_first = tx_idx; end
      end
    end
    check("press_events", q.size(), 2);
    if (q.size() >= 2) begin
      check("press_latency", q[0], 7);
      check("first_repeat", q[1], 23);
    end
    check("press_data", 32'(d_first), 32'h A5);
    check("press_idx", 32'(i_first), 2);
    @(negedge clk);
    btn_in = '0;
    repeat (20) @(negedge clk);

    // Bounce on button 0
    c0 = n_valid;
    for (int t = 0; t < 10; t++) begin
      btn_in[0] = ~btn_in[0];
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_events", n_valid - c0, 0);

    // Hold button 1 for 60 cycles
    c0 = n_valid; c1 = n_valid2;
    btn_in = 4'b0010;
    repeat (60) @(negedge clk);
    btn_in = '0;
    repeat (20) @(negedge clk);
    check("repeat_events", n_valid - c0, 4);
    check("norepeat_events", n_valid2 - c1, 1);

    // Backpressure with three simultaneous presses
    rstn = 1'b0; @(negedge clk); rstn = 1'b1;
    tx_ready = 1'b0; sw_in = 8'h5A; btn_in = 4'b1011;
    repeat (8) @(negedge clk);
    sw_in = 8'hFF;
    repeat (2) @(negedge clk);
    check("stall_valid", 32'(tx_valid), 1);
    check("stall_idx", 32'(tx_idx), 0);
    check("stall_data", 32'(tx_data), 32'h5A);
    q.delete();
    q.push_back(int'(tx_idx));
    btn_in = '0; tx_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (tx_valid) q.push_back(int'(tx_idx));
    end
    check("order_count", q.size(), 3);
    if (q.size() >= 3) begin
      check("order_second", q[1], 1);
      check("order_third", q[2], 3);
    end

    // Pointer wrapped to 0 after granting 3
    @(negedge clk);
    repeat (10) @(negedge clk);
    tx_ready = 1'b0; btn_in = 4'b1001;
    repeat (10) @(negedge clk);
    check("rr_first", 32'(tx_idx), 0);
    btn_in = '0; tx_ready = 1'b1;
    @(posedge clk); #1;
    check("rr_second", 32'(tx_idx), 3);

    // LED write, then reset with a stalled event and two pending
    @(negedge clk);
    repeat (10) @(negedge clk);
    led_wdata = 8'h3C; led_wvalid = 1'b1;
    @(posedge clk); #1;
    check("led_write", 32'(led_out), 32'h3C);
    @(negedge clk);
    led_wvalid = 1'b0; led_wdata = '0;
    tx_ready = 1'b0; btn_in = 4'b0111;
    repeat (10) @(negedge clk);
    check("pre_rst_valid", 32'(tx_valid), 1);
    rstn = 1'b0; btn_in = '0;
    @(negedge clk);
    rstn = 1'b1; tx_ready = 1'b1;
    check("post_rst_valid", 32'(tx_valid), 0);
    check("post_rst_led", 32'(led_out), 0);
    c0 = n_valid;
    repeat (30) @(negedge clk);
    check("post_rst_events", n_valid - c0, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) begin
        bi = int'($urandom_range(NB - 1));
        btn_in[bi] = ~btn_in[bi];
      end
      tx_ready   = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) sw_in = DW'($urandom);
      led_wvalid = ($urandom_range(7) == 0);
      led_wdata  = DW'($urandom);
      rstn       = ($urandom_range(599) != 0);
      @(negedge clk);
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_hub.md
Name: gpio_hub

Overview:
- Parametrised successor of the board GPIO block: NUM_BTN debounced push buttons, a DATA_W-bit slide-switch bank and a DATA_W-bit LED register.
- Each qualified button press (and optional hold auto-repeat) produces one event.
- Events are arbitrated round-robin into a single valid/ready output carrying the switch snapshot and the button index.
- Sits between the board pins and the UART transmit path; the LED register is written from the UART receive path.

Parameters:
- NUM_BTN, 4: number of push buttons, range 1..16.
- DATA_W, 8: width of the switch bank, LED register and tx_data.
- DEB_CYC, 20000: consecutive stable cycles needed to accept a level change; must be >= 2.
- HOLD_CYC, 10000000: hold time before the first auto-repeat and between repeats.
- REPEAT_EN, 1: 1 = auto-repeat while held; 0 = one event per press.
- IDX_W, $clog2(NUM_BTN) with minimum 1: width of tx_idx (localparam).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- sw_in  in  DATA_W  raw asynchronous switch levels.
- led_wdata  in  DATA_W  LED write data.
- led_wvalid  in  1  LED write strobe.
- led_out  out  DATA_W  LED drive.
- tx_data  out  DATA_W  switch snapshot for the event.
- tx_idx  out  IDX_W  index of the originating button.
- tx_valid  out  1  event available.
- tx_ready  in  1  consumer accepts the event.

Behaviour:
- Reset (rstn=0 at a clk edge): clears every register.
  - All outputs go to 0.
  - Sync flops, debounce counters, stable states, hold counters and pending bits go to 0.
  - The round-robin pointer goes to 0.
  - Reset mid-debounce or mid-handshake discards everything; no event is emitted after release.
- Synchronisers: btn_in and sw_in each pass through 2 flops. Only the synchronised values (btn_s, sw_s) are used downstream.
- Debounce, per channel i, with stable state st[i] and counter dc[i]:
  - If btn_s[i]==st[i]: dc <= 0.
  - Else if dc==DEB_CYC-1: st <= btn_s, dc <= 0.
  - Else: dc <= dc+1.
  - A glitch shorter than DEB_CYC cycles never changes st.
- Press event: at the edge where st[i] goes 0->1, pend[i] <= 1. A release generates no event.
- Auto-repeat (REPEAT_EN=1):
  - Hold counter hc[i] counts while st[i]==1 and is held at 0 while st[i]==0.
  - When hc reaches HOLD_CYC-1: hc <= 0 and pend[i] <= 1.
  - With REPEAT_EN=0, hc is held at 0.
- Merging: an event for a channel whose pend bit is already 1 merges into it (no queueing). If an event and a grant of the same channel coincide, pend stays 1.
- Output slot: free when tx_valid==0, or tx_valid&&tx_ready.
- Grant:
  - When the slot is free and any pend bit is set, pick the first set bit searching upward (wrapping) from rr_ptr.
  - Load tx_idx <= i and tx_data <= sw_s, set tx_valid <= 1, clear pend[i], and set rr_ptr <= i+1 (mod NUM_BTN).
  - If the slot is free and nothing is pending, tx_valid <= 0.
- Hold: while tx_valid&&!tx_ready, tx_data and tx_idx are frozen.
- Back-to-back: with tx_ready held at 1, one event is delivered per cycle.
- Latency:
  - btn_in rise to st rise: 2+DEB_CYC cycles.
  - st rise to pend set: same edge.
  - Pend to tx_valid: next edge, if the slot is free.
- LED: on led_wvalid, led_out <= led_wdata; otherwise hold.
- Counter widths: $clog2(DEB_CYC) and $clog2(HOLD_CYC) bits; counters never wrap past their terminal value.

Decomposition:
- Package gpio_hub_pkg:
  - Default constants DEB_CYC_DEF and HOLD_CYC_DEF.
  - Function rr_pick(pend, ptr), returning the found flag and the index.
- Sub-module btn_conditioner, one instance per button:
  - Contains the 2-flop sync, debounce and hold counter.
  - Outputs st and a 1-cycle evt pulse.
- gpio_hub contains the switch sync, pending bits, arbiter, output register and LED register.

Test Plan:
Directed tests use NUM_BTN=4, DEB_CYC=4, HOLD_CYC=16 and REPEAT_EN=1 unless stated.
- Clean press: sw_in=8'hA5, btn_in[2] held at 1, tx_ready=1 -> tx_valid pulses exactly one cycle, 7 cycles after the rise (2 sync + 4 debounce + 1 grant), with tx_data=A5 and tx_idx=2; no further event before cycle 16 of hold.
- Bounce and glitch: btn_in[0] toggles every 2 cycles for 20 cycles, then holds at 0 -> no tx_valid ever; st[0] stays 0.
- Auto-repeat: btn_in[1] held for 60 cycles -> 1 press event plus repeats at 16-cycle intervals (3 repeats total). With REPEAT_EN=0 -> exactly 1 event.
- Backpressure and arbitration: buttons 0, 1 and 3 pressed in the same cycle, tx_ready=0 for 10 cycles, then 1 -> tx_idx order 0,1,3; tx_data/tx_idx stable while stalled; pending merges with no loss or duplication.
- Round-robin fairness: after idx 3 is granted, buttons 0 and 3 both pending -> grant 0 first (pointer has wrapped).
- Reset mid-operation: rstn=0 for 1 cycle while tx_valid=1 and pend=4'b0110 -> the next cycle has tx_valid=0, led_out=0 and no events afterwards. A led_wvalid write of 8'h3C is visible on led_out one cycle later.
